// File: rtl/text_buffer_pkg.sv
// Shared definitions for the text_buffer block.
//   - Default screen geometry (80 x 30 character cells).
//   - Control-byte constants understood by the terminal logic.
//   - FSM state encoding (also exported on text_buffer.dbg_state).
package text_buffer_pkg;

  localparam int COLS_DEFAULT = 80;
  localparam int ROWS_DEFAULT = 30;

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_CLEAR_ROW = 2'd2
  } state_t;

endpackage

// File: rtl/text_buffer_char_ram.sv
// char_ram: simple dual-port character RAM for text_buffer.
//   Synchronous write port, registered (1-cycle) read port; the read
//   register has a synchronous active-low reset so rd_char reads 0 in reset.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (read register only)
//   we, waddr, wdata  write port
//   raddr, rdata      read port, rdata valid one cycle after raddr
module char_ram #(
  parameter int DEPTH  = 2400,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-before-write on a same-address collision: the new byte is seen
  // on the following read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/text_buffer.sv
// text_buffer: character screen buffer fed by a UART byte stream and read
// by a VGA renderer.
//   Printable bytes are written at the cursor; CR, LF, BS and FF move the
//   cursor / clear the screen. After reset the whole RAM is blanked.
// Optional feature: define TEXT_BUFFER_SCROLL_EN to scroll the screen on a
//   row advance from the last row (rotating top offset + single-row clear).
//   Without it the cursor wraps to row 0 and nothing is cleared.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rx_data, rx_valid incoming byte, one-cycle strobe
//   rd_col, rd_row    renderer read position (logical row)
//   rd_char           character at that position, one cycle later
//   cur_col, cur_row  cursor position (logical row)
//   busy              high while CLEAR or CLEAR_ROW runs
//   overflow          sticky: a byte arrived while busy (cleared by reset)
//   dbg_state         current FSM state (text_buffer_pkg::state_t)
// Handshake: rx_valid has no ready; a byte is consumed only if busy=0 in
//   the same cycle, otherwise it is dropped and overflow is set.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [7:0] rd_char,
  output logic [6:0] cur_col,
  output logic [4:0] cur_row,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);
  localparam logic [5:0]        ROWS_W6   = 6'(ROWS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

  state_t            state, state_nxt;
  logic [6:0]        col_q, col_nxt;
  logic [4:0]        row_q, row_nxt;
  logic [4:0]        top_q, top_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic [ADDR_W-1:0] clr_end, clr_end_nxt;
  logic              ovf_q, ovf_nxt;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic              rd_in_range;
  logic [4:0]        cur_prow;
  logic              adv_row;

  // Logical row -> physical row: (lrow + top) mod ROWS, both inputs < ROWS.
  function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] top);
    logic [5:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= ROWS_W6) begin
      sum = sum - ROWS_W6;
    end
    return sum[4:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return ADDR_W'(prow) * COLS_A + ADDR_W'(col);
  endfunction

  assign cur_prow = phys_row(row_q, top_q);

  // Out-of-range renderer coordinates read cell 0 so the RAM never sees an
  // address beyond DEPTH-1.
  assign rd_in_range = (rd_col <= COL_LAST) && (rd_row <= ROW_LAST);
  assign ram_raddr   = rd_in_range ? cell_addr(phys_row(rd_row, top_q), rd_col) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      col_q    <= '0;
      row_q    <= '0;
      top_q    <= '0;
      clr_addr <= '0;
      clr_end  <= ADDR_LAST;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      col_q    <= col_nxt;
      row_q    <= row_nxt;
      top_q    <= top_nxt;
      clr_addr <= clr_addr_nxt;
      clr_end  <= clr_end_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    col_nxt      = col_q;
    row_nxt      = row_q;
    top_nxt      = top_q;
    clr_addr_nxt = clr_addr;
    clr_end_nxt  = clr_end;
    ovf_nxt      = ovf_q;
    ram_we       = 1'b0;
    ram_waddr    = cell_addr(cur_prow, col_q);
    ram_wdata    = CH_SPACE;
    adv_row      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data >= CH_PRINT_LO && rx_data <= CH_PRINT_HI) begin
            ram_we    = 1'b1;
            ram_wdata = rx_data;
            if (col_q == COL_LAST) begin
              col_nxt = '0;
              adv_row = 1'b1;
            end else begin
              col_nxt = col_q + 7'd1;
            end
          end else begin
            case (rx_data)
              CH_CR: col_nxt = '0;
              CH_LF: adv_row = 1'b1;
              CH_BS: begin
                if (col_q != 7'd0) begin
                  col_nxt   = col_q - 7'd1;
                  ram_we    = 1'b1;
                  ram_waddr = cell_addr(cur_prow, col_q - 7'd1);
                end
              end
              CH_FF: begin
                state_nxt    = ST_CLEAR;
                clr_addr_nxt = '0;
                clr_end_nxt  = ADDR_LAST;
              end
              default: ;
            endcase
          end

          if (adv_row) begin
            if (row_q != ROW_LAST) begin
              row_nxt = row_q + 5'd1;
            end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
              // The old top physical row becomes the new bottom row; blank it.
              top_nxt      = (top_q == ROW_LAST) ? 5'd0 : top_q + 5'd1;
              state_nxt    = ST_CLEAR_ROW;
              clr_addr_nxt = cell_addr(top_q, 7'd0);
              clr_end_nxt  = cell_addr(top_q, COL_LAST);
`else
              row_nxt = '0;
`endif
            end
          end
        end
      end

      ST_CLEAR, ST_CLEAR_ROW: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        if (rx_valid) begin
          ovf_nxt = 1'b1;
        end
        if (clr_addr == clr_end) begin
          state_nxt = ST_IDLE;
          if (state == ST_CLEAR) begin
            col_nxt = '0;
            row_nxt = '0;
            top_nxt = '0;
          end
        end else begin
          clr_addr_nxt = clr_addr + 1'b1;
        end
      end

      default: begin
        state_nxt    = ST_CLEAR;
        clr_addr_nxt = '0;
        clr_end_nxt  = ADDR_LAST;
      end
    endcase
  end

  char_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_char_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we & rst_n),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (rd_char)
  );

  assign cur_col   = col_q;
  assign cur_row   = row_q;
  assign busy      = (state != ST_IDLE);
  assign overflow  = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_text_buffer.sv
// Directed testbench for text_buffer (80 x 30 default geometry).
// Covers reset values, the post-reset clear, printable/control bytes,
// read latency, overflow while busy, last-row behaviour (scroll or wrap
// depending on TEXT_BUFFER_SCROLL_EN) and reset during a clear.
module tb_text_buffer;
  import text_buffer_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] rd_col;
  logic [4:0] rd_row;
  logic [7:0] rd_char;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;
  logic       overflow;
  logic [1:0] dbg_state;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  text_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_char   (rd_char),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic read_cell(input int row, input int col, output logic [7:0] v);
    @(negedge clk);
    rd_row = 5'(row);
    rd_col = 7'(col);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_blank(input string tag);
    int bad;
    logic [7:0] v;
    bad = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        if (v !== 8'h20) bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  // Compares one logical row against the next COLS entries of exp_q.
  task automatic check_row(input string tag, input int row);
    int bad;
    logic [7:0] v;
    logic [7:0] e;
    bad = 0;
    for (int c = 0; c < COLS; c++) begin
      read_cell(row, c, v);
      if (exp_q.size() == 0) begin
        bad++;
      end else begin
        e = exp_q.pop_front();
        if (v !== e) bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  task automatic push_row(input logic [7:0] ch, input int n_ch);
    for (int c = 0; c < COLS; c++) exp_q.push_back((c < n_ch) ? ch : 8'h20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},   cur_col, 0);
    check({tag, "_row"},   cur_row, 0);
    check({tag, "_ovf"},   overflow, 0);
    check({tag, "_rd"},    rd_char, 0);
    check({tag, "_busy"},  busy, 1);
    check({tag, "_state"}, dbg_state, ST_CLEAR);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [7:0] v;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd_row   = '0;
    rd_col   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Post-reset clear: exactly 2400 cycles of busy.
    rst_n = 1'b1;
    wait_idle(3000, cyc);
    check("clear_cycles", cyc, 2400);
    check("idle_after_clear", busy, 0);
    check_blank("blank_after_reset");
    check("home_col", cur_col, 0);
    check("home_row", cur_row, 0);

    // 'A','B' then BS.
    send_byte(8'h41);
    send_byte(8'h42);
    check("ab_col", cur_col, 2);
    read_cell(0, 1, v);
    check("cell_0_1_b", v, 8'h42);
    send_byte(CH_BS);
    read_cell(0, 0, v);
    check("cell_0_0_a", v, 8'h41);
    read_cell(0, 1, v);
    check("cell_0_1_bs", v, 8'h20);
    check("bs_col", cur_col, 1);
    check("bs_row", cur_row, 0);

    // CR, then BS at column 0 does nothing; unknown bytes ignored.
    send_byte(CH_CR);
    check("cr_col", cur_col, 0);
    send_byte(CH_BS);
    send_byte(8'h07);
    send_byte(8'hC1);
    check("bs0_col", cur_col, 0);
    check("bs0_row", cur_row, 0);
    read_cell(0, 0, v);
    check("bs0_cell", v, 8'h41);

    // 80 'x' wraps to the next row.
    for (int i = 0; i < COLS; i++) send_byte(8'h78);
    check("x80_col", cur_col, 0);
    check("x80_row", cur_row, 1);
    read_cell(0, 0, v);
    check("x80_first", v, 8'h78);
    read_cell(0, 79, v);
    check("x80_last", v, 8'h78);
    read_cell(1, 0, v);
    check("x80_next_row", v, 8'h20);

    send_byte(CH_CR);
    send_byte(CH_LF);
    check("crlf_col", cur_col, 0);
    check("crlf_row", cur_row, 2);

    // LF keeps the column.
    send_byte(8'h79);
    send_byte(8'h79);
    send_byte(CH_LF);
    check("lf_col", cur_col, 2);
    check("lf_row", cur_row, 3);

    // Read latency: hold (3,2), send 'z' at the cursor.
    @(negedge clk);
    rd_row = 5'd3;
    rd_col = 7'd2;
    send_byte(8'h7A);
    check("lat_n1", rd_char, 8'h20);
    check("lat_col", cur_col, 3);
    @(negedge clk);
    check("lat_n2", rd_char, 8'h7A);

    // FF followed one cycle later by a byte: byte dropped, overflow set.
    @(negedge clk);
    rx_data  = CH_FF;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_data  = 8'h5A;
    @(negedge clk);
    rx_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ff_busy", busy, 1);
    wait_idle(3000, cyc);
    check("ff_clear_cycles", cyc, 2399);
    check_blank("blank_after_ff");
    check("ff_col", cur_col, 0);
    check("ff_row", cur_row, 0);
    check("ovf_sticky", overflow, 1);

    // Fill rows 0..28 with '0'+row, then 5 chars on row 29.
    for (int r = 0; r < ROWS - 1; r++) begin
      for (int c = 0; c < COLS; c++) send_byte(8'(8'h30 + r));
    end
    for (int i = 0; i < 5; i++) send_byte(8'h4D);
    check("fill_col", cur_col, 5);
    check("fill_row", cur_row, 29);
    send_byte(CH_LF);

`ifdef TEXT_BUFFER_SCROLL_EN
    check("scroll_busy", busy, 1);
    check("scroll_col", cur_col, 5);
    check("scroll_row", cur_row, 29);
    wait_idle(200, cyc);
    check("scroll_cycles", cyc, 80);
    push_row(8'h31, COLS);
    check_row("scroll_row0", 0);
    push_row(8'h4D, 5);
    check_row("scroll_row28", 28);
    push_row(8'h20, 0);
    check_row("scroll_row29", 29);
    send_byte(8'h51);
    read_cell(29, 5, v);
    check("scroll_write", v, 8'h51);
    check("exp_q_empty", exp_q.size(), 0);

    // Reset during CLEAR_ROW.
    send_byte(CH_LF);
    repeat (5) @(negedge clk);
    check("in_clear_row", dbg_state, ST_CLEAR_ROW);
`else
    check("wrap_busy", busy, 0);
    check("wrap_col", cur_col, 5);
    check("wrap_row", cur_row, 0);
    push_row(8'h30, COLS);
    check_row("wrap_row0", 0);
    push_row(8'h4D, 5);
    check_row("wrap_row29", 29);
    send_byte(8'h51);
    read_cell(0, 5, v);
    check("wrap_write", v, 8'h51);
    read_cell(0, 4, v);
    check("wrap_neighbour", v, 8'h30);
    check("exp_q_empty", exp_q.size(), 0);

    // Reset during CLEAR.
    send_byte(CH_FF);
    repeat (5) @(negedge clk);
    check("in_clear", dbg_state, ST_CLEAR);
`endif

    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n = 1'b1;
    wait_idle(3000, cyc);
    check("abort_clear_cycles", cyc, 2400);
    check_blank("blank_after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 Parameter COLS, default 80, character columns per row (640 px / 8 px glyph).
REQ-002 Parameter ROWS, default 30, character rows (480 px / 16 px glyph).
REQ-003 clk  input  1  system clock; the block's only clock.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe marking rx_data valid.
REQ-007 rd_col  input  7  VGA renderer read column.
REQ-008 rd_row  input  5  VGA renderer read row (logical, i.e. screen row).
REQ-009 rd_char  output  8  character at (rd_row, rd_col).
REQ-010 cur_col  output  7  cursor column.
REQ-011 cur_row  output  5  cursor logical row.
REQ-012 busy  output  1  high while a multi-cycle operation is running.
REQ-013 overflow  output  1  sticky flag: a byte arrived while busy.

Function
REQ-014 The character RAM SHALL have COLS*ROWS 8-bit entries; physical address = prow*COLS + col.
REQ-015 rd_char SHALL appear exactly 1 cycle after rd_col/rd_row are presented; the read port SHALL be independent of the write port.
REQ-016 FSM states SHALL be IDLE, CLEAR (full screen), CLEAR_ROW; bytes are accepted only in IDLE with busy=0.
REQ-017 rx_valid while busy=1 SHALL drop the byte and set overflow=1; overflow clears only on reset.
REQ-018 Printable byte 0x20-0x7E accepted in cycle N: written at the cursor position; cur_col advances at edge N+1; rd_char reflects the byte from cycle N+2.
REQ-019 Column advance from COLS-1 SHALL set col=0 and perform a row advance.
REQ-020 0x0D (CR) SHALL set col=0; 0x0A (LF) SHALL perform a row advance with col unchanged.
REQ-021 0x08 (BS) with col>0 SHALL decrement col and write 0x20 at the new position; at col=0 it SHALL do nothing.
REQ-022 0x0C (FF) SHALL enter CLEAR: write 0x20 to all COLS*ROWS entries, 1 per cycle, with busy=1; then set cursor (0,0), set the top offset to 0, and return to IDLE.
REQ-023 All other bytes SHALL be ignored, with no state change.
REQ-024 Row advance with row<ROWS-1 SHALL increment row; behaviour at row ROWS-1 is given in REQ-028/029.
REQ-025 All counters SHALL wrap modulo COLS or ROWS exactly; no out-of-range address is ever issued.

Reset
REQ-026 While rst_n=0 at a clk edge: cur_col=0, cur_row=0, overflow=0, top offset=0, rd_char=0, busy=1, state=CLEAR.
REQ-027 After reset the block SHALL clear the RAM (COLS*ROWS cycles) and then enter IDLE; reset asserted mid-operation SHALL abort the operation and restart the CLEAR.

Configuration
REQ-028 With TEXT_BUFFER_SCROLL_EN defined: a row advance at row ROWS-1 SHALL keep cur_row=ROWS-1, increment the top offset mod ROWS, and enter CLEAR_ROW to write COLS blanks to the new bottom physical row (busy=1 for COLS cycles). Physical row = (logical row + top) mod ROWS, for both read and write.
REQ-029 Without TEXT_BUFFER_SCROLL_EN: a row advance at row ROWS-1 SHALL set row=0 with no clear; the top offset is held at 0 and CLEAR_ROW is never entered.

Structure
REQ-030 A shared package SHALL hold COLS and ROWS defaults, the control-byte constants (BS, LF, FF, CR, SPACE) and the FSM state encoding.
REQ-031 The RAM SHALL be a sub-module char_ram: simple dual-port, synchronous write and 1-cycle registered read, inferable as BRAM.

Verification
REQ-032 Release reset, wait 2400 cycles -> busy=0; every cell reads 0x20; cursor (0,0).
REQ-033 Send 'A','B', then 0x08 -> cells (0,0)=0x41 and (0,1)=0x20; cursor (0,1).
REQ-034 Send 80 'x' -> cursor (1,0); send 0x0D, 0x0A -> cursor (2,0).
REQ-035 Send a byte 1 cycle after 0x0C -> byte dropped, overflow=1; after 2400 cycles the screen is blank.
REQ-036 Fill 30 rows, then LF: with SCROLL_EN, logical row 0 shows the old row 1, row 29 is blank and busy=1 for 80 cycles; without it, cursor is (0,col) and the data is intact.
REQ-037 Assert rst_n=0 during CLEAR_ROW -> outputs match REQ-026 on the next edge and a full CLEAR follows.
